// File: rtl/pcpu_pkg.sv
// Shared definitions for the pcpu core and its memory arbiter: widths,
// opcodes, arbiter state and requester-port encodings.
package pcpu_pkg;

  localparam int unsigned ADDR_W       = 8;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned HOST_MAX_DEF = 4;

  // CPU opcodes (instruction bits [15:12])
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_HALT  = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_BZ    = 4'h9;

  typedef enum logic {
    RUN   = 1'b0,
    SPLIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    PORT_HOST = 2'd0,
    PORT_DATA = 2'd1,
    PORT_INST = 2'd2
  } port_e;

endpackage

// File: rtl/pcpu_rd_hold.sv
// Per-port read return: passes RAM data through on the return cycle and
// holds the last returned word until that port's next read comes back.
module pcpu_rd_hold #(
  parameter int unsigned DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          valid,
  input  logic [DW-1:0] mem_rdata,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] hold;

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold <= '0;
    end else if (valid) begin
      hold <= mem_rdata;
    end
  end

  // Reset masks a return already in flight so nothing leaks out while held.
  always_comb begin
    rvalid = valid & reset;
    rdata  = hold;
    if (!reset) begin
      rdata = '0;
    end else if (valid) begin
      rdata = mem_rdata;
    end
  end

endmodule

// File: rtl/pcpu_mem_arb.sv
// Single-port RAM arbiter for pcpu: host, CPU data and CPU fetch share one
// 1-cycle-latency RAM; cpu_enable freezes the pipeline when the CPU must wait.
module pcpu_mem_arb
  import pcpu_pkg::*;
#(
  parameter int unsigned AW       = ADDR_W,
  parameter int unsigned DW       = DATA_W,
  parameter int unsigned HOST_MAX = HOST_MAX_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_enable
);

  localparam int unsigned CW = $clog2(HOST_MAX + 1);

  state_e        state, state_nxt;
  logic [CW-1:0] host_cnt, cnt_nxt;
  logic          gnt_any;
  port_e         gnt_port;
  logic [2:0]    rd_tag;

  // Priority decode: owed fetch, then host (bounded), then CPU ports.
  always_comb begin
    gnt_any    = 1'b0;
    gnt_port   = PORT_HOST;
    cpu_enable = 1'b0;
    state_nxt  = state;
    cnt_nxt    = host_cnt;
    if (reset) begin
      if (state == SPLIT) begin
        gnt_any    = 1'b1;
        gnt_port   = PORT_INST;
        cpu_enable = 1'b1;
        state_nxt  = RUN;
      end else if (host_req && (host_cnt < CW'(HOST_MAX))) begin
        gnt_any  = 1'b1;
        gnt_port = PORT_HOST;
        cnt_nxt  = host_cnt + CW'(1);
      end else if (i_req && d_req) begin
        gnt_any   = 1'b1;
        gnt_port  = PORT_DATA;
        state_nxt = SPLIT;
      end else if (i_req) begin
        gnt_any    = 1'b1;
        gnt_port   = PORT_INST;
        cpu_enable = 1'b1;
      end else if (d_req) begin
        gnt_any    = 1'b1;
        gnt_port   = PORT_DATA;
        cpu_enable = 1'b1;
      end else begin
        cpu_enable = 1'b1;
      end
      if (cpu_enable || !host_req) begin
        cnt_nxt = '0;
      end
    end
  end

  always_comb begin
    host_gnt  = 1'b0;
    d_gnt     = 1'b0;
    i_gnt     = 1'b0;
    mem_en    = gnt_any;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_any) begin
      case (gnt_port)
        PORT_HOST: begin
          host_gnt  = 1'b1;
          mem_we    = host_we;
          mem_addr  = host_addr;
          mem_wdata = host_wdata;
        end
        PORT_DATA: begin
          d_gnt     = 1'b1;
          mem_we    = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
        end
        PORT_INST: begin
          i_gnt    = 1'b1;
          mem_addr = i_addr;
        end
        default: ;
      endcase
    end
  end

  // rd_tag bit per port marks which requester owns next cycle's RAM data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= RUN;
      host_cnt <= '0;
      rd_tag   <= '0;
    end else begin
      state    <= state_nxt;
      host_cnt <= cnt_nxt;
      rd_tag   <= {i_gnt, d_gnt & ~d_we, host_gnt & ~host_we};
    end
  end

  pcpu_rd_hold #(.DW(DW)) u_host_hold (
    .clock(clock), .reset(reset), .valid(rd_tag[0]), .mem_rdata(mem_rdata),
    .rvalid(host_rvalid), .rdata(host_rdata)
  );

  pcpu_rd_hold #(.DW(DW)) u_data_hold (
    .clock(clock), .reset(reset), .valid(rd_tag[1]), .mem_rdata(mem_rdata),
    .rvalid(d_rvalid), .rdata(d_rdata)
  );

  pcpu_rd_hold #(.DW(DW)) u_inst_hold (
    .clock(clock), .reset(reset), .valid(rd_tag[2]), .mem_rdata(mem_rdata),
    .rvalid(i_rvalid), .rdata(i_rdata)
  );

endmodule

// File: doc/pcpu_mem_arb.md
# pcpu_mem_arb

Single-port memory arbiter and CPU sequencer for the 16-bit pipelined processor (`pcpu`). It shares one synchronous 256×16 RAM between three requesters: the host loader/debug port, the CPU data port (LOAD/STORE) and the CPU instruction-fetch port. It drives the CPU `enable` so the pipeline freezes whenever a CPU access cannot be served in the current cycle. It sits between `pcpu` and the RAM macro.

## Interface
- `AW`, 8, address width (matches `i_addr`/`d_addr`)
- `DW`, 16, data width
- `HOST_MAX`, 4, maximum consecutive host grants before one CPU cycle is forced
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `host_req`, `host_we`  in  1  host access request / write
- `host_addr`  in  AW;  `host_wdata`  in  DW
- `host_gnt`  out  1;  `host_rvalid`  out  1;  `host_rdata`  out  DW
- `i_req`  in  1;  `i_addr`  in  AW  instruction fetch (read only)
- `i_gnt`  out  1;  `i_rvalid`  out  1;  `i_rdata`  out  DW
- `d_req`, `d_we`  in  1;  `d_addr`  in  AW;  `d_wdata`  in  DW  CPU data access
- `d_gnt`  out  1;  `d_rvalid`  out  1;  `d_rdata`  out  DW
- `mem_en`, `mem_we`  out  1;  `mem_addr`  out  AW;  `mem_wdata`  out  DW
- `mem_rdata`  in  DW  RAM read data, valid one cycle after `mem_en && !mem_we`
- `cpu_enable`  out  1  pipeline advance enable to `pcpu`

## Operation
- At most one grant per cycle. Grants and `mem_*` are combinational from the requests, the state and `host_cnt`.
- The state machine has two states, RUN and SPLIT. `host_cnt` is a saturating counter, 0..HOST_MAX.
- In RUN, the first matching rule applies:
  - **Host access.** `host_req && host_cnt < HOST_MAX`: grant host, `cpu_enable=0`, `host_cnt++`.
  - **Dual CPU access.** Else if `i_req && d_req`: grant data, `cpu_enable=0`, next state SPLIT.
  - **Single CPU access.** Else if exactly one of `i_req`/`d_req`: grant it, `cpu_enable=1`.
  - **Idle.** Else no grant, `cpu_enable=1`.
- In SPLIT: grant inst, `cpu_enable=1`, next state RUN. `host_req` is ignored in SPLIT.
- `host_cnt` clears on any cycle with `cpu_enable=1` and on any cycle with `host_req=0`.
- **Write.** The granted `*_we` drives `mem_we`. No rvalid is generated.
- **Read.** A 1-bit registered tag records which port was read. On the next cycle that port's `*_rvalid=1` and its `*_rdata` follows `mem_rdata`.
- Each port's `*_rdata` holds its last returned value, captured in a per-port register, until that port's next read returns. This keeps the data result of a SPLIT stable while the CPU advances.
- A data write to the address currently being fetched has no forwarding. Ordering is by grant order.

## Timing
- Read latency is 1 cycle from grant to rvalid. Grant, `mem_en` and `cpu_enable` are same-cycle.
- A dual CPU access costs 2 cycles: data in cycle t, inst in t+1. `cpu_enable` is 0 in t and 1 in t+1.
- Continuous `host_req` gives HOST_MAX host grants, then one CPU cycle, repeating. CPU throughput is therefore at least 1/(HOST_MAX+1).
- Reset values: all `*_gnt`, `*_rvalid` = 0; all `*_rdata` = 0; `mem_en=mem_we=0`; `mem_addr=mem_wdata=0`; `cpu_enable=0` during reset; state RUN; `host_cnt=0`; read tag cleared.
- Reset asserted mid-operation: any pending rvalid is dropped and no `mem_en` is issued while `reset=0`. The first cycle after release follows the RUN rules.

## Structure
- A shared package `pcpu_pkg` holds:
  - address/data width constants
  - the opcode defines used by the CPU
  - state encoding: RUN=1'b0, SPLIT=1'b1
  - port-ID encoding: HOST=2'd0, DATA=2'd1, INST=2'd2
- One sub-module, `pcpu_rd_hold`, instantiated three times: a capture register plus an rvalid-qualified output mux.

## Test plan
- **Reset.** Hold `reset=0` for 2 cycles with all requests high → every grant and `mem_en` = 0; after release, `host_cnt=0` and state RUN.
- **Single access.** Host writes 0xBEEF to addr 0x10, then `d_req` read of 0x10 → `d_gnt=1`, `cpu_enable=1`; next cycle `d_rvalid=1`, `d_rdata=0xBEEF`.
- **Dual access.** `i_req` and `d_req` both high (i_addr 0x00 holding 0x4935, d_addr 0x10) → cycle t: `d_gnt=1`, `cpu_enable=0`; t+1: `i_gnt=1`, `cpu_enable=1`, `d_rdata=0xBEEF`; t+2: `i_rdata=0x4935`, and `d_rdata` is still 0xBEEF.
- **Host fairness.** `host_req` continuously high for 12 cycles with `i_req=1` → the grant pattern is HHHH-I-HHHH-I-HH, and `cpu_enable=1` only on the I cycles.
- **Host during SPLIT.** `host_req` rises in the SPLIT cycle → inst is granted; host is granted the following cycle.
- **Reset during read.** Assert `reset` in the cycle after a data read grant → `d_rvalid` stays 0 and `d_rdata` becomes 0.
